decode_hazard_ctrl: RTL

Scoreboard-based hazard controller between the Decode stage and the DE pipeline buffer. It tracks in-flight writes to the 8×16 register file and stalls Decode on load-use and write-count hazards. It decides each cycle whether the decoded instruction issues into the DE buffer or a bubble (NOP) is inserted, and it sequences branch flushes.

---
 rtl/decode_hazard_ctrl_if.sv | 36 +++
 rtl/decode_hazard_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl_if.sv
// Decode/hazard-controller bundle: decoded instruction fields, writeback
// port, flush request, and the issue/stall/bubble decision returned to Decode.
interface decode_hazard_ctrl_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
);
    logic                dec_valid;
    logic [ADDR_W-1:0]   dec_src1;
    logic [ADDR_W-1:0]   dec_src2;
    logic                dec_src1_en;
    logic                dec_src2_en;
    logic [ADDR_W-1:0]   dec_dst;
    logic                dec_dst_en;
    logic                dec_is_load;
    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic                flush;
    logic                stall;
    logic                issue;
    logic                bubble;
    logic [NUM_REGS-1:0] busy_vec;

    // Driver side: Decode stage / writeback / branch unit.
    modport master (
        output dec_valid, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
        output dec_dst, dec_dst_en, dec_is_load, wb_en, wb_addr, flush,
        input  stall, issue, bubble, busy_vec
    );

    // Hazard controller side.
    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_src1_en, dec_src2_en,
        input  dec_dst, dec_dst_en, dec_is_load, wb_en, wb_addr, flush,
        output stall, issue, bubble, busy_vec
    );
endinterface

// File: rtl/decode_hazard_ctrl.sv
// Scoreboard hazard controller between Decode and the DE buffer.
// Tracks in-flight register writes, stalls on load-use / write-count
// hazards and sequences branch flushes.
// Build option: DECODE_FWD_EN -- when defined, source hazards use the
// forwarding countdown instead of the in-flight write count.
module decode_hazard_ctrl #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_hazard_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam logic [1:0]  LAT_ALU  = 2'(ALU_LAT);
    localparam logic [1:0]  LAT_LOAD = 2'(LOAD_LAT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH
    } state_t;

    state_t     r_state;
    logic [1:0] r_inflight [NUM_REGS];
    logic [1:0] r_cd       [NUM_REGS];

    logic       w_src1_haz;
    logic       w_src2_haz;
    logic       w_struct_haz;
    logic       w_hazard;
    logic       w_block;
    logic       w_issue;
    logic       w_stall;
    logic       w_alloc;
    logic [1:0] w_alloc_lat;

    // Hazard detection against the scoreboard
    always_comb begin
`ifdef DECODE_FWD_EN
        w_src1_haz = bus.dec_src1_en && (r_cd[bus.dec_src1] != 2'd0);
        w_src2_haz = bus.dec_src2_en && (r_cd[bus.dec_src2] != 2'd0);
`else
        w_src1_haz = bus.dec_src1_en && (r_inflight[bus.dec_src1] != 2'd0);
        w_src2_haz = bus.dec_src2_en && (r_inflight[bus.dec_src2] != 2'd0);
`endif
        w_struct_haz = bus.dec_dst_en && (r_inflight[bus.dec_dst] == 2'd3);
        w_hazard     = bus.dec_valid && (w_src1_haz || w_src2_haz || w_struct_haz);
    end

    // Same-cycle issue/stall decision; flush and reset suppress both
    always_comb begin
        w_block     = !rst_n || bus.flush || (r_state == ST_FLUSH);
        w_stall     = !w_block && w_hazard;
        w_issue     = !w_block && bus.dec_valid && !w_hazard;
        w_alloc     = w_issue && bus.dec_dst_en;
        w_alloc_lat = bus.dec_is_load ? LAT_LOAD : LAT_ALU;
    end

    assign bus.stall  = w_stall;
    assign bus.issue  = w_issue;
    assign bus.bubble = !w_issue;

    // Busy flag per register: any write still outstanding
    always_comb begin
        bus.busy_vec = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus.busy_vec[i] = (r_inflight[i] != 2'd0);
        end
    end

    // Control FSM: RUN / STALL / FLUSH, flush takes priority everywhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else if (bus.flush) begin
            r_state <= ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= w_hazard ? ST_STALL : ST_RUN;
                ST_STALL: r_state <= w_hazard ? ST_STALL : ST_RUN;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // Scoreboard: in-flight counts and forwarding countdowns
    // A same-register issue and writeback cancel, leaving the count as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_inflight[i] <= '0;
                r_cd[i]       <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_alloc && (bus.dec_dst == ADDR_W'(i))) begin
                    if (!(bus.wb_en && (bus.wb_addr == ADDR_W'(i)))) begin
                        r_inflight[i] <= r_inflight[i] + 2'd1;
                    end
                    r_cd[i] <= w_alloc_lat;
                end else begin
                    if (bus.wb_en && (bus.wb_addr == ADDR_W'(i)) &&
                        (r_inflight[i] != 2'd0)) begin
                        r_inflight[i] <= r_inflight[i] - 2'd1;
                    end
                    if (r_cd[i] != 2'd0) begin
                        r_cd[i] <= r_cd[i] - 2'd1;
                    end
                end
            end
        end
    end
endmodule
